// File: rtl/core_param_loader_pkg.sv
// Shared types and constants for the RANC core parameter / neuron-instruction loader.
package core_loader_pkg;

    localparam int unsigned WORD_W           = 32;
    localparam int unsigned WORDS_PER_PARAM  = 12;
    localparam int unsigned ENTRIES_PER_WORD = 16;
    localparam int unsigned WCNT_W           = 4;
    localparam int unsigned ECNT_W           = 4;
    localparam int unsigned CORE_W           = 6;
    localparam int unsigned ADDR_W           = 8;
    localparam int unsigned CNT_W            = 16;

    localparam logic [1:0] TYPE_PARAM = 2'd0;
    localparam logic [1:0] TYPE_INST  = 2'd1;

    // Header word layout, MSB first: type, core id, start address, count-1.
    typedef struct packed {
        logic [1:0]        kind;
        logic [CORE_W-1:0] core_id;
        logic [ADDR_W-1:0] start;
        logic [CNT_W-1:0]  cnt_m1;
    } header_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE_P,
        EMIT,
        CHECK
    } state_t;

endpackage

// File: rtl/core_param_loader_if.sv
// Host word stream (valid/ready) into the loader.
interface core_param_loader_if;
    import core_loader_pkg::*;

    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/core_param_loader_assembler.sv
// param_record_assembler: places 32-bit payload words into a parameter record; the
// completed record is published on record and held until the next one completes.
module param_record_assembler
    import core_loader_pkg::*;
#(
    parameter int unsigned PARAM_WIDTH = 368
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WORD_W-1:0]      word,
    output logic                   full_c,
    output logic [PARAM_WIDTH-1:0] record
);
    localparam int unsigned STAGE_W = WORD_W * (WORDS_PER_PARAM - 1);
    localparam int unsigned TAIL_W  = PARAM_WIDTH - STAGE_W;

    logic [STAGE_W-1:0] stage;
    logic [WCNT_W-1:0]  wcnt;

    // High while the next loaded word completes the record.
    assign full_c = (wcnt == WCNT_W'(WORDS_PER_PARAM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage  <= '0;
            wcnt   <= '0;
            record <= '0;
        end else if (clear) begin
            wcnt <= '0;
        end else if (load) begin
            if (full_c) begin
                record <= {word[TAIL_W-1:0], stage};
                wcnt   <= '0;
            end else begin
                stage[32'(wcnt) * WORD_W +: WORD_W] <= word;
                wcnt <= wcnt + WCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/core_param_loader.sv
// core_param_loader: unpacks a host word stream into per-core parameter records and
// neuron-instruction writes. Optional trailing XOR checksum word: PARAM_LOADER_CHECKSUM_EN.
module core_param_loader
    import core_loader_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 6,
    parameter int unsigned PARAM_WIDTH = 368,
    parameter int unsigned NUM_NEURONS = 256
) (
    input  logic                             clk,
    input  logic                             reset_n,
    core_param_loader_if.slave               s,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [NUM_CORES-1:0]             param_wen,
    output logic [ADDR_W-1:0]                param_address,
    output logic [PARAM_WIDTH-1:0]           param_data_in,
    output logic [NUM_CORES-1:0]             neuron_inst_wen,
    output logic [$clog2(NUM_NEURONS)-1:0]   neuron_inst_address,
    output logic [1:0]                       neuron_inst_data_in
);
    localparam int unsigned NADDR_W = $clog2(NUM_NEURONS);

`ifdef PARAM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
    logic [WORD_W-1:0] csum;
`else
    localparam state_t END_STATE = IDLE;
`endif

    state_t               state;
    logic                 ready;
    logic                 is_inst;
    logic [NUM_CORES-1:0] wen_mask;
    logic [ADDR_W-1:0]    start;
    logic [CNT_W-1:0]     cnt_m1;
    logic [CNT_W-1:0]     idx;
    logic [CNT_W-1:0]     idx_inc;
    logic [WORD_W-1:0]    inst_word;
    logic [ECNT_W-1:0]    slot;
    logic [ECNT_W-1:0]    slot_inc;
    logic                 accept;
    logic                 full_c;
    header_t              hdr;

    assign s.ready  = ready;
    assign accept   = s.valid & ready;
    assign hdr      = header_t'(s.data);
    assign idx_inc  = idx + CNT_W'(1);
    assign slot_inc = slot + ECNT_W'(1);

    // Out-of-range core ids yield an all-zero strobe mask so the payload is swallowed.
    function automatic logic [NUM_CORES-1:0] core_mask(input logic [CORE_W-1:0] id);
        if (32'(id) >= NUM_CORES) return '0;
        return NUM_CORES'(1) << id;
    endfunction

    param_record_assembler #(.PARAM_WIDTH(PARAM_WIDTH)) u_asm (
        .clk    (clk),
        .rst_n  (reset_n),
        .clear  (accept && (state == IDLE)),
        .load   (accept && (state == COLLECT) && !is_inst),
        .word   (s.data),
        .full_c (full_c),
        .record (param_data_in)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            ready               <= 1'b1;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            is_inst             <= 1'b0;
            wen_mask            <= '0;
            start               <= '0;
            cnt_m1              <= '0;
            idx                 <= '0;
            inst_word           <= '0;
            slot                <= '0;
            param_wen           <= '0;
            param_address       <= '0;
            neuron_inst_wen     <= '0;
            neuron_inst_address <= '0;
            neuron_inst_data_in <= '0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            csum                <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hdr.kind == TYPE_PARAM || hdr.kind == TYPE_INST) begin
                            is_inst  <= (hdr.kind == TYPE_INST);
                            wen_mask <= core_mask(hdr.core_id);
                            start    <= hdr.start;
                            cnt_m1   <= hdr.cnt_m1;
                            idx      <= '0;
                            err      <= (32'(hdr.core_id) >= NUM_CORES);
                            state    <= COLLECT;
                            busy     <= 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
`ifdef PARAM_LOADER_CHECKSUM_EN
                        csum <= csum ^ s.data;
`endif
                        if (is_inst) begin
                            inst_word           <= s.data;
                            slot                <= '0;
                            neuron_inst_wen     <= wen_mask;
                            neuron_inst_address <= NADDR_W'(start) + NADDR_W'(idx);
                            neuron_inst_data_in <= s.data[1:0];
                            ready               <= 1'b0;
                            state               <= EMIT;
                        end else if (full_c) begin
                            param_wen     <= wen_mask;
                            param_address <= start + ADDR_W'(idx);
                            ready         <= 1'b0;
                            state         <= WRITE_P;
                        end
                    end
                end
                WRITE_P: begin
                    param_wen <= '0;
                    ready     <= 1'b1;
                    if (idx == cnt_m1) begin
                        state <= END_STATE;
                        busy  <= (END_STATE != IDLE);
                        done  <= (END_STATE == IDLE);
                    end else begin
                        idx   <= idx_inc;
                        state <= COLLECT;
                    end
                end
                EMIT: begin
                    // Stop at the transfer's last entry or at the end of the current word.
                    if (idx == cnt_m1) begin
                        neuron_inst_wen <= '0;
                        ready           <= 1'b1;
                        state           <= END_STATE;
                        busy            <= (END_STATE != IDLE);
                        done            <= (END_STATE == IDLE);
                    end else if (slot == ECNT_W'(ENTRIES_PER_WORD - 1)) begin
                        neuron_inst_wen <= '0;
                        idx             <= idx_inc;
                        ready           <= 1'b1;
                        state           <= COLLECT;
                    end else begin
                        idx                 <= idx_inc;
                        slot                <= slot_inc;
                        neuron_inst_address <= NADDR_W'(start) + NADDR_W'(idx_inc);
                        neuron_inst_data_in <= inst_word[{slot_inc, 1'b0} +: 2];
                    end
                end
`ifdef PARAM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (s.data != csum) err <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    param_wen       <= '0;
                    neuron_inst_wen <= '0;
                    ready           <= 1'b1;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_param_loader.sv
// Self-checking bench for core_param_loader: directed table, hand sequences and random
// transfers checked against a list-of-writes model built from the header/payload rules.
module tb_core_param_loader;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         busy, done, err;
    logic [5:0]   param_wen, neuron_inst_wen;
    logic [7:0]   param_address, neuron_inst_address;
    logic [367:0] param_data_in;
    logic [1:0]   neuron_inst_data_in;

    core_param_loader_if bus();

    core_param_loader dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .s                   (bus),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .param_wen           (param_wen),
        .param_address       (param_address),
        .param_data_in       (param_data_in),
        .neuron_inst_wen     (neuron_inst_wen),
        .neuron_inst_address (neuron_inst_address),
        .neuron_inst_data_in (neuron_inst_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_inst;
        logic [5:0]   wen;
        logic [7:0]   addr;
        logic [367:0] data;
        int           cyc;
        logic         rdy;
    } ev_t;

    typedef struct {
        int   kind;
        int   core;
        int   start;
        int   cnt;
        int   gap;
        logic exp_err;
        int   exp_nwen;
    } vec_t;

    ev_t  obs[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic both_seen = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (param_wen != 6'd0)
                obs.push_back('{1'b0, param_wen, param_address, param_data_in, cyc, bus.ready});
            if (neuron_inst_wen != 6'd0)
                obs.push_back('{1'b1, neuron_inst_wen, neuron_inst_address,
                                368'(neuron_inst_data_in), cyc, bus.ready});
            if (param_wen != 6'd0 && neuron_inst_wen != 6'd0) both_seen <= 1'b1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [383:0] key(input logic ii, input logic [5:0] w,
                                         input logic [7:0] a, input logic [367:0] d);
        return {1'b0, ii, w, a, d};
    endfunction

    task automatic send(input logic [31:0] w, output int acyc);
        int n;
        n = 0;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.data  = w;
        while (bus.ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%b for word %h, expected 1", bus.ready, w);
            bus.valid = 1'b0;
            acyc = cyc;
        end else begin
            @(posedge clk);
            #1;
            bus.valid = 1'b0;
            acyc = cyc;
        end
    endtask

    task automatic idle(input int gap);
        if (gap >= 100) @(negedge clk);
        else if (gap > 0 && int'($urandom_range(0, 99)) < gap)
            repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    task automatic wait_done(input int dc0, input string nm);
        int t;
        t = 0;
        while (done_cnt == dc0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == dc0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: done count %0d, expected %0d", nm, done_cnt, dc0 + 1);
        end
        @(negedge clk);
    endtask

    // Full transfer with random payload; compares observed writes with the model's list.
    task automatic run_xfer(input int kind, input int core, input int start, input int cnt,
                            input int gap, input bit corrupt, input string nm,
                            output int nobs, output logic err_o);
        logic [31:0]  words[$];
        logic [383:0] exp_q[$];
        logic [367:0] rec;
        logic [31:0]  x;
        logic [5:0]   m;
        int nw, dc0, base, a, ncmp;
        nw = (kind == 0) ? 12 * (cnt + 1) : (cnt + 16) / 16;
        for (int i = 0; i < nw; i++) words.push_back($urandom);
        m = (core < 6) ? 6'(1 << core) : 6'd0;
        if (m != 6'd0) begin
            if (kind == 0) begin
                for (int r = 0; r <= cnt; r++) begin
                    rec = '0;
                    for (int k = 0; k < 12; k++) rec = rec | (368'(words[12*r + k]) << (32 * k));
                    exp_q.push_back(key(1'b0, m, 8'(start + r), rec));
                end
            end else begin
                for (int n = 0; n <= cnt; n++) begin
                    x = words[n / 16] >> (2 * (n % 16));
                    exp_q.push_back(key(1'b1, m, 8'(start + n), 368'(x[1:0])));
                end
            end
        end
        base = obs.size();
        dc0  = done_cnt;
        send({2'(kind), 6'(core), 8'(start), 16'(cnt)}, a);
        for (int i = 0; i < nw; i++) begin
            idle(gap);
            send(words[i], a);
        end
`ifdef PARAM_LOADER_CHECKSUM_EN
        x = '0;
        foreach (words[i]) x = x ^ words[i];
        send(corrupt ? (x ^ 32'h1) : x, a);
`else
        if (corrupt) $display("note: checksum disabled, corrupt flag ignored");
`endif
        wait_done(dc0, nm);
        nobs  = obs.size() - base;
        err_o = err;
        chk({nm, "_nwen"}, 384'(nobs), 384'(exp_q.size()));
        ncmp = (nobs < exp_q.size()) ? nobs : exp_q.size();
        for (int i = 0; i < ncmp; i++)
            chk($sformatf("%s_wr%0d", nm, i),
                key(obs[base+i].is_inst, obs[base+i].wen, obs[base+i].addr, obs[base+i].data),
                exp_q[i]);
        chk({nm, "_busy"}, 384'(busy), 384'(0));
    endtask

    initial begin
        vec_t tbl[9];
        int   base, dc0, a, nobs, kind, core, cnt, nw;
        logic e;
        logic [31:0] x;

        tbl[0] = '{0, 0, 'h00, 0,   0,   1'b0, 1};
        tbl[1] = '{0, 5, 'hFF, 1,   50,  1'b0, 2};
        tbl[2] = '{1, 3, 'h10, 15,  0,   1'b0, 16};
        tbl[3] = '{1, 1, 'hF8, 16,  30,  1'b0, 17};
        tbl[4] = '{1, 0, 'h00, 0,   0,   1'b0, 1};
        tbl[5] = '{1, 6, 'h20, 4,   0,   1'b1, 0};
        tbl[6] = '{0, 63,'h40, 0,   0,   1'b1, 0};
        tbl[7] = '{1, 4, 'h80, 255, 20,  1'b0, 256};
        tbl[8] = '{0, 2, 'h7F, 1,   100, 1'b0, 2};

        reset_n   = 1'b0;
        bus.valid = 1'b0;
        bus.data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 384'(bus.ready), 384'(1));
        chk("rst_busy_done_err", 384'({busy, done, err}), 384'(0));
        chk("rst_wen", 384'({param_wen, neuron_inst_wen}), 384'(0));
        chk("rst_addr", 384'({param_address, neuron_inst_address, neuron_inst_data_in}), 384'(0));
        chk("rst_pdata", 384'(param_data_in), 384'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Single PARAM record, core 2 at 0x10, payload 1..12.
        base = obs.size();
        dc0  = done_cnt;
        send(32'h0210_0000, a);
        x = '0;
        for (int k = 1; k <= 12; k++) begin
            send(32'(k), a);
            x = x ^ 32'(k);
        end
        nw = a;
`ifdef PARAM_LOADER_CHECKSUM_EN
        send(x, a);
`endif
        wait_done(dc0, "t1");
        chk("t1_nwen", 384'(obs.size() - base), 384'(1));
        if (obs.size() > base) begin
            chk("t1_wen", 384'(obs[base].wen), 384'(6'b000100));
            chk("t1_addr", 384'(obs[base].addr), 384'(8'h10));
            chk("t1_hi", 384'(obs[base].data[367:352]), 384'(16'h000C));
            chk("t1_lo", 384'(obs[base].data[31:0]), 384'(32'h1));
            chk("t1_wen_latency", 384'(obs[base].cyc), 384'(nw));
`ifndef PARAM_LOADER_CHECKSUM_EN
            chk("t1_done_latency", 384'(done_cyc), 384'(obs[base].cyc + 1));
`endif
        end

        // INST, core 5 at 0xFE, 4 entries from word 0xE4: address wraps, s_ready low.
        base = obs.size();
        dc0  = done_cnt;
        send(32'h45FE_0003, a);
        send(32'h0000_00E4, a);
        nw = a;
`ifdef PARAM_LOADER_CHECKSUM_EN
        send(32'h0000_00E4, a);
`endif
        wait_done(dc0, "t2");
        chk("t2_nwen", 384'(obs.size() - base), 384'(4));
        if (obs.size() >= base + 4) begin
            chk("t2_first_latency", 384'(obs[base].cyc), 384'(nw));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_wr%0d", i),
                    key(obs[base+i].is_inst, obs[base+i].wen, obs[base+i].addr, obs[base+i].data),
                    key(1'b1, 6'b100000, 8'(8'hFE + i), 368'(i)));
                chk($sformatf("t2_ready%0d", i), 384'(obs[base+i].rdy), 384'(0));
            end
        end

        // Out-of-range core: payload consumed, no writes, err; illegal type; err cleared.
        base = obs.size();
        dc0  = done_cnt;
        send(32'h0733_0000, a);
        x = '0;
        for (int k = 0; k < 12; k++) begin
            send(32'(k * 7 + 3), a);
            x = x ^ 32'(k * 7 + 3);
        end
`ifdef PARAM_LOADER_CHECKSUM_EN
        send(x, a);
`endif
        wait_done(dc0, "t3");
        chk("t3_nwen", 384'(obs.size() - base), 384'(0));
        chk("t3_err", 384'(err), 384'(1));
        send(32'hC000_0000, a);
        @(negedge clk);
        chk("t3_illegal_err_busy", 384'({err, busy}), 384'(2'b10));
        dc0 = done_cnt;
        send(32'h4000_0000, a);
        @(negedge clk);
        chk("t3_err_cleared", 384'({err, busy}), 384'(2'b01));
        send(32'h0000_0003, a);
`ifdef PARAM_LOADER_CHECKSUM_EN
        send(32'h0000_0003, a);
`endif
        wait_done(dc0, "t3b");

        // Reset in the middle of a record, then a fresh load.
        send(32'h0120_0000, a);
        for (int k = 0; k < 6; k++) send(32'hDEAD_0000 + 32'(k), a);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_wen", 384'({param_wen, neuron_inst_wen}), 384'(0));
        chk("t4_rst_state", 384'({bus.ready, busy, done, err}), 384'(4'b1000));
        chk("t4_rst_pdata", 384'(param_data_in), 384'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_xfer(0, 1, 'h20, 0, 0, 1'b0, "t4", nobs, e);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_xfer(tbl[i].kind, tbl[i].core, tbl[i].start, tbl[i].cnt, tbl[i].gap, 1'b0,
                     $sformatf("tbl%0d", i), nobs, e);
            chk($sformatf("tbl%0d_nwen_table", i), 384'(nobs), 384'(tbl[i].exp_nwen));
            chk($sformatf("tbl%0d_err", i), 384'(e), 384'(tbl[i].exp_err));
        end

`ifdef PARAM_LOADER_CHECKSUM_EN
        run_xfer(0, 3, 'h05, 0, 0, 1'b1, "t6_bad", nobs, e);
        chk("t6_bad_err", 384'(e), 384'(1));
        run_xfer(1, 2, 'h30, 20, 0, 1'b0, "t6_good", nobs, e);
        chk("t6_good_err", 384'(e), 384'(0));
`endif

        // Random transfers.
        for (int i = 0; i < 16; i++) begin
            kind = int'($urandom_range(0, 1));
            core = int'($urandom_range(0, 7));
            cnt  = (kind == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 40));
            run_xfer(kind, core, int'($urandom_range(0, 255)), cnt, int'($urandom_range(0, 60)),
                     1'b0, $sformatf("rnd%0d", i), nobs, e);
            chk($sformatf("rnd%0d_err", i), 384'(e), 384'(core >= 6));
        end

        chk("both_wen_never", 384'(both_seen), 384'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
